// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared types and constants for the note sequencer.
// Note table values are half-period counts at 50 MHz (50e6 / (2 * f)), C5..C6.
package note_seq_pkg;

  localparam int unsigned NOTE_NUM    = 8;
  localparam logic [31:0] RESET_COUNT = 32'd47801;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } note_state_e;

  localparam logic [31:0] NOTE_TABLE [NOTE_NUM] = '{
    32'd47801, 32'd42589, 32'd37936, 32'd35816,
    32'd31928, 32'd28409, 32'd25329, 32'd23900
  };

  // Half-period count for a note index; every entry is non-zero.
  function automatic logic [31:0] note_count(input logic [2:0] idx);
    return NOTE_TABLE[idx];
  endfunction

endpackage

// File: rtl/note_sequencer_sync_edge.sv
// sync_edge: 2-flop synchronizer for W asynchronous bits, with an optional
// extra register giving a one-cycle rising-edge strobe per bit.
// Synchronous active-high reset clears every flop.
module sync_edge #(
  parameter int unsigned W       = 1,
  parameter bit          EDGE_EN = 1'b1
) (
  input  logic         inclk,
  input  logic         Reset,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] level_out,
  output logic [W-1:0] rise_out
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  // Next values of the two synchronizer stages.
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  // Synchronizer stages.
  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge inclk) begin
    if (Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign level_out = sync_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic [W-1:0] prev_q, prev_d;

      // Previous synchronized value for edge detection.
      always_comb prev_d = sync_q;

      // Edge-detect history register.
      always_ff @(posedge inclk) begin
        if (Reset) prev_q <= '0;
        else       prev_q <= prev_d;
      end

      assign rise_out = sync_q & ~prev_q;
    end else begin : g_no_edge
      assign rise_out = '0;
    end
  endgenerate

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: picks one of eight notes (manual switches or auto stepping)
// and drives the tone divider's half-period count and synchronous reset.
// Build option: define NOTE_SEQ_GAP_EN to insert a silent GAP between auto notes;
// without it, auto expiry steps the note with a one-cycle divider reset pulse.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000
) (
  input  logic        inclk,
  input  logic        Reset,
  input  logic [2:0]  note_sel,
  input  logic        mode_auto,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] div_clk_count,
  output logic        div_reset,
  output logic [2:0]  note_idx,
  output logic        playing
);

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

  logic       start_rise, stop_rise;
  logic [1:0] unused_ctl_lvl;
  logic [2:0] note_sel_lvl;
  logic       mode_lvl;
  logic [3:0] unused_sw_rise;

  sync_edge #(.W(2), .EDGE_EN(1'b1)) u_sync_ctl (
    .inclk     (inclk),
    .Reset     (Reset),
    .async_in  ({stop, start}),
    .level_out (unused_ctl_lvl),
    .rise_out  ({stop_rise, start_rise})
  );

  sync_edge #(.W(4), .EDGE_EN(1'b0)) u_sync_sw (
    .inclk     (inclk),
    .Reset     (Reset),
    .async_in  ({mode_auto, note_sel}),
    .level_out ({mode_lvl, note_sel_lvl}),
    .rise_out  (unused_sw_rise)
  );

  note_state_e state_q, state_d;
  logic [2:0]  note_idx_q, note_idx_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] div_clk_count_q, div_clk_count_d;
  logic        div_reset_q, div_reset_d;
  logic        playing_q, playing_d;
  logic        mode_prev_q, mode_prev_d;
  logic        pulse;
  logic        mode_chg;

  // Next-state, note selection, timer and registered-output logic.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    note_idx_d  = note_idx_q;
    timer_d     = timer_q + 32'd1;
    pulse       = 1'b0;
    mode_chg    = (mode_lvl != mode_prev_q);
    mode_prev_d = mode_lvl;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (start_rise) begin
          state_d    = ST_PLAY;
          note_idx_d = note_sel_lvl;
        end
      end
      ST_PLAY: begin
        if (!mode_lvl) begin
          // Manual: timer idles at 0; a new switch value restarts the divider.
          timer_d = '0;
          if (note_sel_lvl != note_idx_q) begin
            note_idx_d = note_sel_lvl;
            pulse      = 1'b1;
          end
        end else if (mode_chg) begin
          timer_d = '0;
        end else if (timer_q == NOTE_LAST) begin
          timer_d = '0;
`ifdef NOTE_SEQ_GAP_EN
          state_d = ST_GAP;
`else
          note_idx_d = note_idx_q + 3'd1;
          pulse      = 1'b1;
`endif
        end
      end
      ST_GAP: begin
        if (!mode_lvl) begin
          state_d = ST_PLAY;
          timer_d = '0;
          if (note_sel_lvl != note_idx_q) begin
            note_idx_d = note_sel_lvl;
            pulse      = 1'b1;
          end
        end else if (timer_q == GAP_LAST) begin
          state_d    = ST_PLAY;
          timer_d    = '0;
          note_idx_d = note_idx_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Stop overrides everything, including a same-cycle start.
    if (stop_rise) begin
      state_d    = ST_IDLE;
      note_idx_d = note_idx_q;
      timer_d    = '0;
      pulse      = 1'b0;
    end

    div_reset_d     = (state_d != ST_PLAY) || pulse;
    playing_d       = (state_d != ST_IDLE);
    div_clk_count_d = note_count(note_idx_d);
  end

  // State, timer and output registers with synchronous reset.
  always_ff @(posedge inclk) begin
    if (Reset) begin
      state_q         <= ST_IDLE;
      note_idx_q      <= '0;
      timer_q         <= '0;
      div_clk_count_q <= RESET_COUNT;
      div_reset_q     <= 1'b1;
      playing_q       <= 1'b0;
      mode_prev_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      note_idx_q      <= note_idx_d;
      timer_q         <= timer_d;
      div_clk_count_q <= div_clk_count_d;
      div_reset_q     <= div_reset_d;
      playing_q       <= playing_d;
      mode_prev_q     <= mode_prev_d;
    end
  end

  assign div_clk_count = div_clk_count_q;
  assign div_reset     = div_reset_q;
  assign note_idx      = note_idx_q;
  assign playing       = playing_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench for note_sequencer with short note/gap times.
// Expected output snapshots are queued as stimulus is applied and compared per cycle.
module tb_note_sequencer;

  localparam int unsigned NOTE_CYC = 10;
  localparam int unsigned GAP_CYC  = 3;

  logic        inclk = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  note_sel = 3'd0;
  logic        mode_auto = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] div_clk_count;
  logic        div_reset;
  logic [2:0]  note_idx;
  logic        playing;

  typedef struct packed {
    logic [31:0] count;
    logic [2:0]  idx;
    logic        dr;
    logic        pl;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  note_sequencer #(.NOTE_CYCLES(NOTE_CYC), .GAP_CYCLES(GAP_CYC)) dut (
    .inclk         (inclk),
    .Reset         (Reset),
    .note_sel      (note_sel),
    .mode_auto     (mode_auto),
    .start         (start),
    .stop          (stop),
    .div_clk_count (div_clk_count),
    .div_reset     (div_reset),
    .note_idx      (note_idx),
    .playing       (playing)
  );

  always #5 inclk = ~inclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_count(input int idx);
    case (idx)
      0: return 32'd47801;
      1: return 32'd42589;
      2: return 32'd37936;
      3: return 32'd35816;
      4: return 32'd31928;
      5: return 32'd28409;
      6: return 32'd25329;
      default: return 32'd23900;
    endcase
  endfunction

  function automatic obs_t mk(input int idx, input logic dr, input logic pl);
    obs_t o;
    o.count = ref_count(idx);
    o.idx   = 3'(idx);
    o.dr    = dr;
    o.pl    = pl;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.count = div_clk_count;
    o.idx   = note_idx;
    o.dr    = div_reset;
    o.pl    = playing;
    return o;
  endfunction

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic push(input string name, input obs_t v);
    exp_t e;
    e.name = name;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  // Reset held then released with inputs quiet: outputs sit at reset values.
  task automatic test_reset();
    exp_t e;
    obs_t o;
    for (int j = 0; j < 5; j++) push($sformatf("reset_idle_%0d", j), mk(0, 1'b1, 1'b0));
    for (int j = 0; j < 5; j++) begin
      tick();
      if (j == 1) Reset = 1'b0;
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got count=%0d idx=%0d div_reset=%b playing=%b, want count=%0d idx=%0d div_reset=%b playing=%b",
                 e.name, o.count, o.idx, o.dr, o.pl, e.v.count, e.v.idx, e.v.dr, e.v.pl);
      end
    end
  endtask

  // Manual start with note_sel=5: playing appears on the third edge, not before.
  task automatic test_manual_start();
    exp_t e;
    obs_t o;
    note_sel = 3'd5;
    repeat (3) tick();
    start = 1'b1;
    push("start_lat_e1", mk(0, 1'b1, 1'b0));
    push("start_lat_e2", mk(0, 1'b1, 1'b0));
    push("start_play_e3", mk(5, 1'b0, 1'b1));
    push("start_play_e4", mk(5, 1'b0, 1'b1));
    for (int j = 0; j < 4; j++) begin
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got count=%0d idx=%0d div_reset=%b playing=%b, want count=%0d idx=%0d div_reset=%b playing=%b",
                 e.name, o.count, o.idx, o.dr, o.pl, e.v.count, e.v.idx, e.v.dr, e.v.pl);
      end
    end
    start = 1'b0;
    repeat (2) tick();
  endtask

  // Manual note change 5 -> 2 while playing: one-cycle div_reset pulse at the new count.
  task automatic test_note_change();
    exp_t e;
    obs_t o;
    note_sel = 3'd2;
    push("chg_e1", mk(5, 1'b0, 1'b1));
    push("chg_e2", mk(5, 1'b0, 1'b1));
    push("chg_pulse", mk(2, 1'b1, 1'b1));
    push("chg_after", mk(2, 1'b0, 1'b1));
    push("chg_steady", mk(2, 1'b0, 1'b1));
    for (int j = 0; j < 5; j++) begin
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got count=%0d idx=%0d div_reset=%b playing=%b, want count=%0d idx=%0d div_reset=%b playing=%b",
                 e.name, o.count, o.idx, o.dr, o.pl, e.v.count, e.v.idx, e.v.dr, e.v.pl);
      end
    end
  endtask

  // Stop mid-play, then simultaneous start and stop edges from IDLE.
  task automatic test_stop();
    exp_t e;
    obs_t o;
    stop = 1'b1;
    push("stop_e1", mk(2, 1'b0, 1'b1));
    push("stop_e2", mk(2, 1'b0, 1'b1));
    push("stop_idle", mk(2, 1'b1, 1'b0));
    for (int j = 0; j < 3; j++) begin
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got count=%0d idx=%0d div_reset=%b playing=%b, want count=%0d idx=%0d div_reset=%b playing=%b",
                 e.name, o.count, o.idx, o.dr, o.pl, e.v.count, e.v.idx, e.v.dr, e.v.pl);
      end
    end
    stop = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    stop  = 1'b1;
    for (int j = 0; j < 5; j++) push($sformatf("both_idle_%0d", j), mk(2, 1'b1, 1'b0));
    for (int j = 0; j < 5; j++) begin
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got count=%0d idx=%0d div_reset=%b playing=%b, want count=%0d idx=%0d div_reset=%b playing=%b",
                 e.name, o.count, o.idx, o.dr, o.pl, e.v.count, e.v.idx, e.v.dr, e.v.pl);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) tick();
  endtask

  // Reference sequence for auto mode starting at note 7; j=0 is the first PLAY cycle.
  function automatic obs_t auto_ref(input int j);
`ifdef NOTE_SEQ_GAP_EN
    if (j < int'(NOTE_CYC))                 return mk(7, 1'b0, 1'b1);
    else if (j < int'(NOTE_CYC + GAP_CYC))  return mk(7, 1'b1, 1'b1);
    else                                    return mk(0, 1'b0, 1'b1);
`else
    if (j < int'(NOTE_CYC))       return mk(7, 1'b0, 1'b1);
    else if (j == int'(NOTE_CYC)) return mk(0, 1'b1, 1'b1);
    else                          return mk(0, 1'b0, 1'b1);
`endif
  endfunction

  // Auto stepping from note 7: full PLAY length, GAP (or pulse), then wrap to 0.
  task automatic test_auto();
    exp_t e;
    obs_t o;
    mode_auto = 1'b1;
    note_sel  = 3'd7;
    repeat (3) tick();
    start = 1'b1;
    repeat (2) tick();
    for (int j = 0; j < 15; j++) push($sformatf("auto_cyc_%0d", j), auto_ref(j));
    for (int j = 0; j < 15; j++) begin
      tick();
      if (j == 2) start = 1'b0;
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got count=%0d idx=%0d div_reset=%b playing=%b, want count=%0d idx=%0d div_reset=%b playing=%b",
                 e.name, o.count, o.idx, o.dr, o.pl, e.v.count, e.v.idx, e.v.dr, e.v.pl);
      end
    end
  endtask

  // Reset while silent-but-playing (GAP, or the step pulse without GAP).
  task automatic test_reset_mid();
    exp_t e;
    obs_t o;
    bit   found = 1'b0;
    for (int j = 0; j < 40 && !found; j++) begin
      tick();
      if (div_reset === 1'b1 && playing === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_mid_wait: got no silent playing cycle within 40 cycles, want one");
    end
    Reset     = 1'b1;
    mode_auto = 1'b0;
    for (int j = 0; j < 3; j++) push($sformatf("reset_mid_%0d", j), mk(0, 1'b1, 1'b0));
    for (int j = 0; j < 3; j++) begin
      tick();
      if (j == 0) Reset = 1'b0;
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e.v) begin
        bad++;
        $display("FAIL %s: got count=%0d idx=%0d div_reset=%b playing=%b, want count=%0d idx=%0d div_reset=%b playing=%b",
                 e.name, o.count, o.idx, o.dr, o.pl, e.v.count, e.v.idx, e.v.dr, e.v.pl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual_start();
    test_note_change();
    test_stop();
    test_auto();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Control stage directly upstream of the divided-clock tone generator. Selects one of eight musical notes from switches (manual) or steps through them on a timer (auto). Drives the divider's 32-bit half-period count and its synchronous reset, so the tone starts, stops and changes note with a clean phase. Runs entirely in the `inclk` domain.

## Interface
- `NOTE_CYCLES`, 25_000_000: auto-mode note length in `inclk` cycles (0.5 s at 50 MHz); must be ≥2.
- `GAP_CYCLES`, 2_500_000: silent gap between auto-mode notes in `inclk` cycles; must be ≥1.
- `inclk`  in  1  system clock, 50 MHz.
- `Reset`  in  1  reset, synchronous, active-high; clock `inclk`.
- `note_sel`  in  3  manual note index; asynchronous switches.
- `mode_auto`  in  1  1 = auto step, 0 = manual; asynchronous switch.
- `start`  in  1  play request, asynchronous, active-high; rising edge acts.
- `stop`  in  1  stop request, asynchronous, active-high; rising edge acts.
- `div_clk_count`  out  32  half-period count to the divider.
- `div_reset`  out  1  reset to the divider; 1 = tone silent and held low.
- `note_idx`  out  3  index of the note currently selected.
- `playing`  out  1  1 while in PLAY or GAP.

## Operation
- All four async inputs pass through 2-flop synchronizers. `start` and `stop` get a further register for rising-edge detection.
- Note table, index 0..7, value = 50e6/(2·f): 47801, 42589, 37936, 35816, 31928, 28409, 25329, 23900 (C5..C6).
- `div_clk_count` = table[`note_idx`], registered. It is never 0.
- States:
  - IDLE: `div_reset`=1, `playing`=0.
  - PLAY: `div_reset`=0.
  - GAP: `div_reset`=1.
- IDLE → PLAY on a start edge. `note_idx` loads the synchronized `note_sel` and the duration timer clears.
- Any state → IDLE on a stop edge. If start and stop edges occur in the same cycle, stop wins.
- Start edge while in PLAY or GAP: ignored.
- Manual mode, PLAY, synchronized `note_sel` differs from `note_idx`:
  - `note_idx` updates.
  - `div_reset` pulses 1 for exactly that one cycle, so the divider restarts at the new pitch.
- Auto mode:
  - PLAY lasts `NOTE_CYCLES` cycles, then GAP for `GAP_CYCLES` cycles, then PLAY.
  - `note_idx` increments on GAP → PLAY and wraps 7 → 0.
- Mode changes while playing:
  - Auto → manual: timer clears; `note_idx` follows `note_sel` under the manual rule. Leaving GAP this way goes to PLAY.
  - Manual → auto: timer clears; PLAY continues from the current `note_idx`.
- Duration timer: 32-bit unsigned. Clears on every state entry. The terminal compare is `count == N-1`; the timer never wraps.
- Reset values: state IDLE, `note_idx`=0, `div_clk_count`=47801, `div_reset`=1, `playing`=0, timer 0, synchronizers 0. Reset mid-note forces these on the next edge.

## Timing
- Async input change sampled at edge k → visible in synchronized form after edge k+1. A resulting state or output change is registered at edge k+2.
- Start latency: `playing`=1 and `div_reset`=0 both appear after edge k+2.
- Auto PLAY: exactly `NOTE_CYCLES` cycles of `div_reset`=0. GAP: exactly `GAP_CYCLES` cycles of `div_reset`=1.
- `div_clk_count` and `note_idx` change on the same edge. `div_reset` is high in that cycle whenever the change happens during PLAY.

## Configuration
- `NOTE_SEQ_GAP_EN` defined: GAP state and `GAP_CYCLES` behave as above.
- Undefined:
  - No GAP state; `GAP_CYCLES` is ignored.
  - Auto PLAY expiry increments `note_idx` with a single-cycle `div_reset` pulse and stays in PLAY.

## Structure
- Package `note_seq_pkg` holds:
  - the state enum (IDLE, PLAY, GAP);
  - the 8-entry note-count constant table;
  - the note count (8) and reset count (47801) constants.
- One sub-module, `sync_edge`: 2-flop synchronizer plus rising-edge detect, synchronous reset. Instantiated for `start` and `stop`; the level-only path is used for `note_sel` and `mode_auto`.

## Test plan
- Reset, then hold idle → `div_reset`=1, `playing`=0, `div_clk_count`=47801, `note_idx`=0.
- Manual, `note_sel`=5, pulse `start` → after 3 edges: `playing`=1, `div_clk_count`=28409, `div_reset`=0.
- While playing, `note_sel` 5 → 2 → single-cycle `div_reset` pulse; `div_clk_count`=37936 in that cycle.
- Auto, `NOTE_CYCLES`=10, `GAP_CYCLES`=3, start at idx 7 → 10 cycles PLAY, 3 cycles GAP, then idx 0 with count 47801. With the macro undefined: 1-cycle pulse only.
- `start` and `stop` edges in the same cycle while in IDLE → stays IDLE. `stop` mid-PLAY → IDLE, `div_reset`=1.
- `Reset` asserted mid-GAP → all outputs at reset values after the next edge.
